memory_bus_arbiter: RTL and testbench

MEMORY_BUS_ARBITER -- requirements
Module: memory_bus_arbiter

---
 rtl/memory_bus_arbiter_pkg.sv | 19 +
 rtl/memory_bus_arbiter.sv | 111 +++++++++++
 tb/tb_memory_bus_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/memory_bus_arbiter_pkg.sv
// Shared encodings and default widths for the instruction/data cache memory bus arbiter.
package memory_bus_arbiter_pkg;

  localparam int DEFAULT_ADDR_W  = 6;
  localparam int DEFAULT_BLOCK_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    DONE  = 2'b11
  } ArbState;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } Owner;

endpackage

// File: rtl/memory_bus_arbiter.sv
// Round-robin arbiter giving the instruction and data caches turns on one shared block memory.
module memory_bus_arbiter
  import memory_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int BLOCK_W = DEFAULT_BLOCK_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               icREAD,
  input  logic [ADDR_W-1:0]  icADDRESS,
  output logic [BLOCK_W-1:0] icREADDATA,
  output logic               icBUSYWAIT,
  input  logic               dcREAD,
  input  logic               dcWRITE,
  input  logic [ADDR_W-1:0]  dcADDRESS,
  input  logic [BLOCK_W-1:0] dcWRITEDATA,
  output logic [BLOCK_W-1:0] dcREADDATA,
  output logic               dcBUSYWAIT,
  output logic               memREAD,
  output logic               memWRITE,
  output logic [ADDR_W-1:0]  memADDRESS,
  output logic [BLOCK_W-1:0] memWRITEDATA,
  input  logic [BLOCK_W-1:0] memREADDATA,
  input  logic               memBUSYWAIT
);

  ArbState state, nextState;
  Owner    owner, lastOwner, winner;
  logic    dcReq, grant, complete;

  assign dcReq = dcREAD | dcWRITE;

  // On a tie the cache that did not have the previous turn wins.
  always_comb begin
    winner = OWNER_I;
    if (icREAD && dcReq) begin
      if (lastOwner == OWNER_I) winner = OWNER_D;
    end else if (dcReq) begin
      winner = OWNER_D;
    end
  end

  always_comb begin
    nextState = state;
    grant     = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (icREAD || dcReq) begin
          grant     = 1'b1;
          nextState = ISSUE;
        end
      end
      ISSUE: nextState = WAIT;
      WAIT: begin
        if (!memBUSYWAIT) begin
          complete  = 1'b1;
          nextState = DONE;
        end
      end
      DONE: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Bus request registers are loaded at grant and held until the access completes.
  always_ff @(posedge clock) begin
    if (reset) begin
      owner        <= OWNER_I;
      lastOwner    <= OWNER_D;
      memREAD      <= 1'b0;
      memWRITE     <= 1'b0;
      memADDRESS   <= '0;
      memWRITEDATA <= '0;
      icREADDATA   <= '0;
      dcREADDATA   <= '0;
    end else begin
      if (grant) begin
        owner <= winner;
        if (winner == OWNER_I) begin
          memADDRESS <= icADDRESS;
          memREAD    <= 1'b1;
          memWRITE   <= 1'b0;
        end else begin
          memADDRESS   <= dcADDRESS;
          memWRITEDATA <= dcWRITEDATA;
          memREAD      <= ~dcWRITE;
          memWRITE     <= dcWRITE;
        end
      end
      if (complete) begin
        memREAD   <= 1'b0;
        memWRITE  <= 1'b0;
        lastOwner <= owner;
        if (memREAD) begin
          if (owner == OWNER_I) icREADDATA <= memREADDATA;
          else                  dcREADDATA <= memREADDATA;
        end
      end
    end
  end

  assign icBUSYWAIT = icREAD & ~((state == DONE) && (owner == OWNER_I));
  assign dcBUSYWAIT = dcReq & ~((state == DONE) && (owner == OWNER_D));

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Bench for memory_bus_arbiter: directed scenarios then random traffic against a transaction-level model.
module tb_memory_bus_arbiter;

  logic         clock = 1'b0;
  logic         reset;
  logic         icREAD;
  logic [5:0]   icADDRESS;
  logic [127:0] icREADDATA;
  logic         icBUSYWAIT;
  logic         dcREAD;
  logic         dcWRITE;
  logic [5:0]   dcADDRESS;
  logic [127:0] dcWRITEDATA;
  logic [127:0] dcREADDATA;
  logic         dcBUSYWAIT;
  logic         memREAD;
  logic         memWRITE;
  logic [5:0]   memADDRESS;
  logic [127:0] memWRITEDATA;
  logic [127:0] memREADDATA;
  logic         memBUSYWAIT;

  logic [127:0] romData [64];
  logic [5:0]   grantAddr [$];
  logic         prevStrobe = 1'b0;
  int           total = 0;
  int           bad = 0;

  memory_bus_arbiter dut (
    .clock(clock), .reset(reset),
    .icREAD(icREAD), .icADDRESS(icADDRESS), .icREADDATA(icREADDATA), .icBUSYWAIT(icBUSYWAIT),
    .dcREAD(dcREAD), .dcWRITE(dcWRITE), .dcADDRESS(dcADDRESS), .dcWRITEDATA(dcWRITEDATA),
    .dcREADDATA(dcREADDATA), .dcBUSYWAIT(dcBUSYWAIT),
    .memREAD(memREAD), .memWRITE(memWRITE), .memADDRESS(memADDRESS),
    .memWRITEDATA(memWRITEDATA), .memREADDATA(memREADDATA), .memBUSYWAIT(memBUSYWAIT)
  );

  always #5 clock = ~clock;

  assign memREADDATA = romData[memADDRESS];

  // Reference model: one transaction at a time, tracked as busy / issue cycle / done cycle.
  logic         mBusy = 1'b0, mIssue = 1'b0, mDoneCyc = 1'b0, mForD = 1'b0, mLastD = 1'b1;
  logic         mRd = 1'b0, mWr = 1'b0;
  logic [5:0]   mAddr = '0;
  logic [127:0] mWdata = '0, mIcData = '0, mDcData = '0;
  logic         pickD;

  assign pickD = (dcREAD || dcWRITE) && (!icREAD || !mLastD);

  always @(posedge clock) begin
    if (reset) begin
      mBusy <= 1'b0; mIssue <= 1'b0; mDoneCyc <= 1'b0; mLastD <= 1'b1;
      mRd <= 1'b0; mWr <= 1'b0; mAddr <= '0; mWdata <= '0; mIcData <= '0; mDcData <= '0;
    end else if (!mBusy) begin
      if (icREAD || dcREAD || dcWRITE) begin
        mBusy  <= 1'b1;
        mIssue <= 1'b1;
        mForD  <= pickD;
        mAddr  <= pickD ? dcADDRESS : icADDRESS;
        if (pickD) mWdata <= dcWRITEDATA;
        mWr <= pickD && dcWRITE;
        mRd <= !(pickD && dcWRITE);
      end
    end else if (mDoneCyc) begin
      mBusy    <= 1'b0;
      mDoneCyc <= 1'b0;
    end else if (mIssue) begin
      mIssue <= 1'b0;
    end else if (!memBUSYWAIT) begin
      mDoneCyc <= 1'b1;
      mLastD   <= mForD;
      if (mRd) begin
        if (mForD) mDcData <= romData[mAddr];
        else       mIcData <= romData[mAddr];
      end
      mRd <= 1'b0;
      mWr <= 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got %h want %h", tag, $time, observed, expected);
    end
  endtask

  task automatic checkAll();
    checkOutput("icBusy", 128'(icBUSYWAIT), 128'(icREAD && !(mDoneCyc && !mForD)));
    checkOutput("dcBusy", 128'(dcBUSYWAIT), 128'((dcREAD || dcWRITE) && !(mDoneCyc && mForD)));
    checkOutput("memRd", 128'(memREAD), 128'(mRd));
    checkOutput("memWr", 128'(memWRITE), 128'(mWr));
    checkOutput("memAddr", 128'(memADDRESS), 128'(mAddr));
    checkOutput("memWdata", memWRITEDATA, mWdata);
    checkOutput("icData", icREADDATA, mIcData);
    checkOutput("dcData", dcREADDATA, mDcData);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clock);
      checkAll();
      if ((memREAD || memWRITE) && !prevStrobe) grantAddr.push_back(memADDRESS);
      prevStrobe = memREAD || memWRITE;
    end
  endtask

  task automatic applyStimulus(input int budget);
    int n = 0;
    while ((icREAD || dcREAD || dcWRITE) && n < budget) begin
      step(1);
      n++;
      if (icREAD && !icBUSYWAIT) icREAD = 1'b0;
      if ((dcREAD || dcWRITE) && !dcBUSYWAIT) begin
        dcREAD  = 1'b0;
        dcWRITE = 1'b0;
      end
    end
    checkOutput("drain", 128'(icREAD || dcREAD || dcWRITE), 128'(0));
    icREAD = 1'b0; dcREAD = 1'b0; dcWRITE = 1'b0;
    step(2);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 64; i++) romData[i] = {$urandom, $urandom, $urandom, $urandom};
    romData[5] = {16{8'hA5}};
    reset = 1'b1; icREAD = 1'b0; icADDRESS = '0; dcREAD = 1'b0; dcWRITE = 1'b0;
    dcADDRESS = '0; dcWRITEDATA = '0; memBUSYWAIT = 1'b0;
    step(2);
    reset = 1'b0;
    step(1);

    // Lone instruction read with a zero-wait memory.
    icREAD = 1'b1; icADDRESS = 6'h05;
    step(1);
    checkOutput("loneRd", 128'(memREAD), 128'(1));
    checkOutput("loneAddr", 128'(memADDRESS), 128'(6'h05));
    step(2);
    checkOutput("loneBusy", 128'(icBUSYWAIT), 128'(0));
    checkOutput("loneData", icREADDATA, {16{8'hA5}});
    icREAD = 1'b0;
    step(1);

    // Simultaneous requests right after reset: I wins, then the D write.
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    grantAddr.delete();
    icREAD = 1'b1; icADDRESS = 6'h07;
    dcWRITE = 1'b1; dcADDRESS = 6'h12; dcWRITEDATA = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(30);
    checkOutput("tieCnt", 128'(grantAddr.size()), 128'(2));
    checkOutput("tieFirst", 128'(grantAddr[0]), 128'(6'h07));
    checkOutput("tieSecond", 128'(grantAddr[1]), 128'(6'h12));

    // Both caches hold their requests for four turns.
    grantAddr.delete();
    icREAD = 1'b1; icADDRESS = 6'h01; dcREAD = 1'b1; dcADDRESS = 6'h02;
    n = 0;
    while (grantAddr.size() < 4 && n < 60) begin
      step(1);
      n++;
    end
    icREAD = 1'b0; dcREAD = 1'b0;
    step(6);
    checkOutput("fairCnt", 128'(grantAddr.size()), 128'(4));
    for (int i = 0; i < 4; i++)
      checkOutput("fairOrder", 128'(grantAddr[i]), 128'((i % 2 == 0) ? 6'h01 : 6'h02));

    // Memory holds busywait for five WAIT cycles.
    dcREAD = 1'b1; dcADDRESS = 6'h2A; memBUSYWAIT = 1'b1;
    step(1);
    for (int i = 0; i < 5; i++) begin
      step(1);
      checkOutput("waitBusy", 128'(dcBUSYWAIT), 128'(1));
      checkOutput("waitAddr", 128'(memADDRESS), 128'(6'h2A));
    end
    memBUSYWAIT = 1'b0;
    step(1);
    checkOutput("waitDone", 128'(dcBUSYWAIT), 128'(0));
    dcREAD = 1'b0;
    step(2);

    // Reset lands while the access is waiting on memory.
    dcREAD = 1'b1; dcADDRESS = 6'h03; memBUSYWAIT = 1'b1;
    step(2);
    reset = 1'b1;
    step(1);
    checkOutput("rstRd", 128'(memREAD), 128'(0));
    checkOutput("rstWr", 128'(memWRITE), 128'(0));
    reset = 1'b0; memBUSYWAIT = 1'b0;
    grantAddr.delete();
    applyStimulus(20);
    checkOutput("rstServe", 128'(grantAddr[0]), 128'(6'h03));
    checkOutput("rstData", dcREADDATA, romData[3]);

    // Request withdrawn during WAIT still completes and is not granted again.
    icREAD = 1'b1; icADDRESS = 6'h09; memBUSYWAIT = 1'b1;
    step(2);
    icREAD = 1'b0;
    step(1);
    memBUSYWAIT = 1'b0;
    step(1);
    checkOutput("dropData", icREADDATA, romData[9]);
    grantAddr.delete();
    step(3);
    checkOutput("noRegrant", 128'(grantAddr.size()), 128'(0));

    // Random traffic, random memory stalls and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      step(1);
      reset       = ($urandom_range(0, 199) == 0);
      memBUSYWAIT = ($urandom_range(0, 3) == 0);
      if (icREAD && (!icBUSYWAIT || $urandom_range(0, 39) == 0)) begin
        icREAD = 1'b0;
      end else if (!icREAD && $urandom_range(0, 2) == 0) begin
        icREAD    = 1'b1;
        icADDRESS = 6'($urandom);
      end
      if ((dcREAD || dcWRITE) && (!dcBUSYWAIT || $urandom_range(0, 39) == 0)) begin
        dcREAD  = 1'b0;
        dcWRITE = 1'b0;
      end else if (!(dcREAD || dcWRITE) && $urandom_range(0, 2) == 0) begin
        {dcREAD, dcWRITE} = 2'($urandom_range(1, 3));
        dcADDRESS   = 6'($urandom);
        dcWRITEDATA = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
